// File: rtl/soc_pkg.sv
// Shared SoC constants for the UART TX path: drain FSM encoding, default FIFO
// depth and UART register map offsets.
package soc_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_LOW  = 2'd1,
      WAIT_HIGH = 2'd2
   } drain_state_t;

   localparam int UART_TX_FIFO_DEPTH = 16;

   localparam logic [31:0] UART_BASE_ADDR  = 32'h4000_1000;
   localparam logic [7:0]  UART_DATA_OFS   = 8'h00;
   localparam logic [7:0]  UART_STATUS_OFS = 8'h04;
   localparam logic [7:0]  UART_LEVEL_OFS  = 8'h08;
   localparam logic [7:0]  UART_OVF_OFS    = 8'h0C;

   function automatic logic [31:0] uart_reg_addr(input logic [7:0] ofs);
      return UART_BASE_ADDR + {24'd0, ofs};
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO storage with wrapping pointers and an occupancy counter.
// The storage array is deliberately left without reset.
module sync_fifo
   import soc_pkg::*;
#(
   parameter int DEPTH = UART_TX_FIFO_DEPTH,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     empty,
   output logic                     full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   // A full FIFO rejects the push even if a pop frees a slot this cycle.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   assign pop_data = mem[rd_ptr];
   assign level    = count;
   assign empty    = (count == '0);
   assign full     = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO between the bus-side UART data register and the UART core.
// Optional sticky overflow flag (ovf/ovf_clr) when UART_TX_FIFO_OVF_EN is defined.
//
// state     | meaning
// ----------|-----------------------------------------------------------
// IDLE      | waiting for data and an idle UART; pops and sends a byte
// WAIT_LOW  | send issued, waiting for tx_ready to drop (guard timeout)
// WAIT_HIGH | UART busy, waiting for tx_ready to return high
module uart_tx_fifo
   import soc_pkg::*;
#(
   parameter int DEPTH        = UART_TX_FIFO_DEPTH,
   parameter int GUARD_CYCLES = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [7:0]               push_data,
   input  logic                     push_valid,
   output logic                     push_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     empty,
   output logic                     full,
   output logic [7:0]               tx_data,
   output logic                     tx_send,
   input  logic                     tx_ready
`ifdef UART_TX_FIFO_OVF_EN
  ,input  logic                     ovf_clr,
   output logic                     ovf
`endif
);

   localparam int GW = $clog2(GUARD_CYCLES + 1);
   localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES);

   drain_state_t state;
   drain_state_t state_nxt;
   logic [GW-1:0] guard_cnt;
   logic [GW-1:0] guard_nxt;
   logic          pop;
   logic [7:0]    fifo_head;

   sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_valid),
      .push_data (push_data),
      .pop       (pop),
      .pop_data  (fifo_head),
      .level     (level),
      .empty     (empty),
      .full      (full)
   );

   assign push_ready = !full;

   always_comb begin
      state_nxt = state;
      guard_nxt = guard_cnt;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (!empty && tx_ready) begin
               pop       = 1'b1;
               guard_nxt = GUARD_LOAD;
               state_nxt = WAIT_LOW;
            end
         end
         WAIT_LOW: begin
            // Guard against a UART that never acknowledges the send.
            if (!tx_ready) begin
               state_nxt = WAIT_HIGH;
            end else if (guard_cnt == GW'(1)) begin
               state_nxt = IDLE;
            end else begin
               guard_nxt = guard_cnt - GW'(1);
            end
         end
         WAIT_HIGH: begin
            if (tx_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         guard_cnt <= '0;
         tx_send   <= 1'b0;
         tx_data   <= 8'h00;
      end else begin
         state     <= state_nxt;
         guard_cnt <= guard_nxt;
         tx_send   <= pop;
         if (pop) begin
            tx_data <= fifo_head;
         end
      end
   end

`ifdef UART_TX_FIFO_OVF_EN
   // Set has priority so a drop coinciding with a clear is never lost.
   always_ff @(posedge clk) begin
      if (reset) begin
         ovf <= 1'b0;
      end else if (push_valid && full) begin
         ovf <= 1'b1;
      end else if (ovf_clr) begin
         ovf <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: expected bytes queued on accepted pushes,
// popped and compared on every tx_send; includes a simple UART ready model.
module tb_uart_tx_fifo;

   localparam int DEPTH = 16;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          reset;
   logic [7:0]    push_data;
   logic          push_valid;
   logic          push_ready;
   logic [LW-1:0] level;
   logic          empty;
   logic          full;
   logic [7:0]    tx_data;
   logic          tx_send;
   logic          tx_ready;
`ifdef UART_TX_FIFO_OVF_EN
   logic          ovf_clr;
   logic          ovf;
`endif

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   push_edge;
   bit   uart_auto;
   bit   ready_hold;
   logic prev_send = 1'b0;
   logic [7:0] exp_q[$];
   int         send_cyc[$];

   uart_tx_fifo #(
      .DEPTH        (DEPTH),
      .GUARD_CYCLES (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .push_data  (push_data),
      .push_valid (push_valid),
      .push_ready (push_ready),
      .level      (level),
      .empty      (empty),
      .full       (full),
      .tx_data    (tx_data),
      .tx_send    (tx_send),
      .tx_ready   (tx_ready)
`ifdef UART_TX_FIFO_OVF_EN
     ,.ovf_clr    (ovf_clr),
      .ovf        (ovf)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_push(input logic [7:0] d, input bit exp_accept);
      push_data  = d;
      push_valid = 1'b1;
      check_val("push_ready", 32'(push_ready), 32'(exp_accept));
      if (exp_accept) exp_q.push_back(d);
   endtask

   task automatic set_auto(input bit v);
      @(posedge clk);
      #2 uart_auto = v;
   endtask

   // Scoreboard: every send must match the oldest outstanding byte.
   always @(negedge clk) begin
      if (tx_send) begin
         check_val("send_gap", 32'(prev_send), 32'd0);
         send_cyc.push_back(cyc);
         if (exp_q.size() == 0) check_val("send_with_empty_model", 32'(tx_send), 32'd0);
         else check_val("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
      end
      prev_send = tx_send;
   end

   // UART model: auto mode drops ready for 10 cycles per byte, manual mode follows ready_hold.
   initial begin
      tx_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (uart_auto && tx_send) begin
            @(posedge clk);
            #1 tx_ready = 1'b0;
            repeat (10) @(posedge clk);
            #1 tx_ready = 1'b1;
         end else begin
            @(posedge clk);
            #1 tx_ready = uart_auto ? 1'b1 : ready_hold;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset      = 1'b1;
      push_valid = 1'b0;
      push_data  = 8'h00;
      ready_hold = 1'b1;
      uart_auto  = 1'b1;
`ifdef UART_TX_FIFO_OVF_EN
      ovf_clr    = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check_val("rst_empty", 32'(empty), 32'd1);
      check_val("rst_full", 32'(full), 32'd0);
      check_val("rst_push_ready", 32'(push_ready), 32'd1);
      check_val("rst_level", 32'(level), 32'd0);
      check_val("rst_tx_send", 32'(tx_send), 32'd0);
      check_val("rst_tx_data", 32'(tx_data), 32'd0);
`ifdef UART_TX_FIFO_OVF_EN
      check_val("rst_ovf", 32'(ovf), 32'd0);
`endif
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Single byte into an empty FIFO with the UART idle.
      send_cyc.delete();
      push_edge = cyc + 1;
      drive_push(8'h41, 1'b1);
      @(negedge clk);
      push_valid = 1'b0;
      for (int i = 0; i < 20 && send_cyc.size() == 0; i++) @(negedge clk);
      check_val("single_send_count", 32'(send_cyc.size()), 32'd1);
      if (send_cyc.size() > 0)
         check_val("send_sample_edge", 32'(send_cyc[0] + 1), 32'(push_edge + 2));
      repeat (15) @(negedge clk);
      check_val("single_level", 32'(level), 32'd0);
      check_val("single_empty", 32'(empty), 32'd1);
      check_val("tx_data_hold", 32'(tx_data), 32'h41);

      // Fill with the UART held busy, then overflow.
      ready_hold = 1'b0;
      set_auto(1'b0);
      repeat (3) @(negedge clk);
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         drive_push(8'(i), 1'b1);
      end
      @(negedge clk);
      check_val("fill_level", 32'(level), 32'd16);
      check_val("fill_full", 32'(full), 32'd1);
      drive_push(8'hFF, 1'b0);
      @(negedge clk);
      push_valid = 1'b0;
      check_val("drop_level", 32'(level), 32'd16);
`ifdef UART_TX_FIFO_OVF_EN
      check_val("ovf_set", 32'(ovf), 32'd1);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      check_val("ovf_clear", 32'(ovf), 32'd0);
`endif

      // Push while full in the same cycle as a pop: rejected, level drops by one.
      send_cyc.delete();
      ready_hold = 1'b1;
      @(negedge clk);
      ready_hold = 1'b0;
      drive_push(8'hEE, 1'b0);
`ifdef UART_TX_FIFO_OVF_EN
      ovf_clr = 1'b1;
`endif
      @(negedge clk);
      push_valid = 1'b0;
      check_val("push_pop_full_level", 32'(level), 32'd15);
      check_val("push_pop_full_flag", 32'(full), 32'd0);
`ifdef UART_TX_FIFO_OVF_EN
      check_val("ovf_set_wins", 32'(ovf), 32'd1);
      ovf_clr = 1'b0;
`endif

      // Drain the rest through the UART model.
      set_auto(1'b1);
      for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(negedge clk);
      check_val("drain_remaining", 32'(exp_q.size()), 32'd0);
      repeat (15) @(negedge clk);
      check_val("drain_send_count", 32'(send_cyc.size()), 32'd16);
      check_val("drain_level", 32'(level), 32'd0);
      check_val("drain_empty", 32'(empty), 32'd1);

      // UART never drops ready: guard timeout returns to IDLE, next byte follows.
      ready_hold = 1'b1;
      set_auto(1'b0);
      repeat (3) @(negedge clk);
      send_cyc.delete();
      @(negedge clk);
      drive_push(8'h55, 1'b1);
      @(negedge clk);
      drive_push(8'hAA, 1'b1);
      @(negedge clk);
      push_valid = 1'b0;
      for (int i = 0; i < 50 && send_cyc.size() < 2; i++) @(negedge clk);
      check_val("stuck_send_count", 32'(send_cyc.size()), 32'd2);
      if (send_cyc.size() >= 2)
         check_val("stuck_send_spacing", 32'(send_cyc[1] - send_cyc[0]), 32'd3);

      // Reset with bytes queued discards them.
      ready_hold = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         drive_push(8'(8'h60 + i), 1'b1);
      end
      @(negedge clk);
      push_valid = 1'b0;
      check_val("queued_level", 32'(level), 32'd5);
      reset = 1'b1;
      exp_q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check_val("mid_rst_empty", 32'(empty), 32'd1);
      check_val("mid_rst_level", 32'(level), 32'd0);
      check_val("mid_rst_tx_send", 32'(tx_send), 32'd0);
`ifdef UART_TX_FIFO_OVF_EN
      check_val("mid_rst_ovf", 32'(ovf), 32'd0);
`endif
      send_cyc.delete();
      ready_hold = 1'b1;
      repeat (30) @(negedge clk);
      check_val("sends_after_reset", 32'(send_cyc.size()), 32'd0);
      check_val("post_rst_empty", 32'(empty), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, 2..256).
REQ-002 SHALL have parameter GUARD_CYCLES, default 2, maximum cycles to wait for tx_ready to fall after a send.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock, all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 push_data  in  8  byte from the bus-side UART data register write.
REQ-007 push_valid  in  1  one-cycle write strobe.
REQ-008 push_ready  out  1  equals !full.
REQ-009 level  out  $clog2(DEPTH)+1  occupied entries.
REQ-010 empty, full  out  1 each  status, readable over the memory-mapped bus.
REQ-011 tx_data  out  8  byte to the UART transmitter.
REQ-012 tx_send  out  1  one-cycle send request to the UART.
REQ-013 tx_ready  in  1  UART idle indication.

Function
REQ-014 Push SHALL be accepted iff push_valid && !full; the byte is written at that edge.
REQ-015 Pointers SHALL wrap modulo DEPTH; level SHALL range 0..DEPTH.
REQ-016 Full: push_valid SHALL drop the byte with no state change. There is no same-cycle bypass, even when a pop occurs in the same cycle.
REQ-017 Simultaneous accepted push and pop SHALL leave level unchanged.
REQ-018 Drain FSM SHALL have states IDLE, WAIT_LOW, WAIT_HIGH.
REQ-019 IDLE: if !empty && tx_ready, pop the head, register tx_data, pulse tx_send for 1 cycle, then go to WAIT_LOW.
REQ-020 WAIT_LOW: go to WAIT_HIGH when tx_ready==0. If tx_ready stays 1 for GUARD_CYCLES cycles, go to IDLE.
REQ-021 WAIT_HIGH: go to IDLE when tx_ready==1.
REQ-022 Latency: a byte pushed into an empty FIFO at edge N with tx_ready=1 SHALL produce tx_send=1 during cycle N+2.
REQ-023 tx_send SHALL never be high on consecutive cycles.
REQ-024 tx_data SHALL hold its value until the next pop.
REQ-025 Bytes SHALL be emitted in strict push order, with no loss unless REQ-016 applies.

Reset
REQ-026 On reset: pointers=0, level=0, empty=1, full=0, push_ready=1, tx_send=0, tx_data=0, FSM=IDLE.
REQ-027 Reset mid-transfer SHALL discard all queued bytes. It SHALL NOT retract a tx_send already presented to the UART.
REQ-028 Storage array contents SHALL NOT need reset.

Configuration
REQ-029 Macro UART_TX_FIFO_OVF_EN defined: add input ovf_clr (1) and output ovf (1).
REQ-030 ovf SHALL be a sticky flag set by a dropped push and cleared by ovf_clr. Set SHALL win over clear in the same cycle. ovf SHALL reset to 0.
REQ-031 Macro undefined: ports ovf and ovf_clr SHALL be absent and overflow SHALL be silent.

Structure
REQ-032 The shared package soc_pkg SHALL hold the FSM state encoding, the default DEPTH and the UART register address/offset constants.
REQ-033 Storage and pointers SHALL be a sub-module sync_fifo (push/pop/level/empty/full). The drain FSM SHALL stay in uart_tx_fifo.

Verification
REQ-034 Push 0x41 into the empty FIFO with tx_ready=1 -> tx_send pulses 2 cycles later with tx_data=0x41; level returns to 0.
REQ-035 Push 0x01..0x10 back-to-back with tx_ready held 0 -> full=1 and level=16 after the 16th push; a 17th push of 0xFF is dropped; with OVF_EN, ovf=1.
REQ-036 Release tx_ready with a UART model (ready low 10 cycles per byte) -> bytes 0x01..0x10 are emitted in order, one tx_send per byte.
REQ-037 With the FIFO full, push_valid is asserted in the same cycle as a pop -> the push is rejected; level=15 next cycle.
REQ-038 tx_ready stuck at 1 after a send -> FSM returns to IDLE after 2 cycles; the next byte is sent.
REQ-039 Reset asserted with 5 bytes queued -> empty=1, level=0, no further tx_send; ovf=0.
